aes_round_sequencer: RTL and testbench

//  Control stage between aes_ahb_interface and the iterative AES-128 round datapath.
//  - Detects a rising edge on the CTRL start level and latches key and plaintext.
//  - Issues NUM_ROUNDS+1 round commands (round 0 = initial AddRoundKey) to the datapath over a start/done handshake.
//  - Captures the final state as ciphertext and raises a sticky DONE. This drives the interface's aes_ciphertext and DONE inputs.

---
 rtl/aes_round_sequencer.sv | 137 +++++++++++++
 tb/tb_aes_round_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Round sequencer for an iterative AES-128 datapath: latches key/text on a start
// edge, issues one command per round over a start/done handshake, captures the result.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS     = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         start,
  input  logic [127:0] aes_key,
  input  logic [127:0] aes_plaintext,
  output logic         dp_start,
  output logic [3:0]   dp_round,
  output logic         dp_final,
  output logic [127:0] dp_key,
  output logic [127:0] dp_text,
  input  logic         dp_done,
  input  logic [127:0] dp_state,
  output logic [127:0] aes_ciphertext,
  output logic         DONE,
  output logic         busy,
  output logic         err_timeout
);

  // state | meaning
  // IDLE  | waiting for a rising edge on start; results and flags hold
  // ISSUE | one-cycle round command to the datapath, round timer reloaded
  // WAIT  | waiting for dp_done; timer counts down, abort at terminal count
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam int              TW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      LAST_RND = 4'(NUM_ROUNDS);

  state_t         state_q, state_d;
  logic           start_q, start_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   text_q, text_d;
  logic [127:0]   ct_q, ct_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic           trig;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      rnd_q   <= '0;
      tmr_q   <= '0;
      key_q   <= '0;
      text_q  <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      rnd_q   <= rnd_d;
      tmr_q   <= tmr_d;
      key_q   <= key_d;
      text_q  <= text_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = start;
    rnd_d   = rnd_q;
    tmr_d   = tmr_q;
    key_d   = key_q;
    text_d  = text_q;
    ct_d    = ct_q;
    done_d  = done_q;
    busy_d  = busy_q;
    err_d   = err_q;
    trig    = start & ~start_q;

    case (state_q)
      IDLE: begin
        if (trig) begin
          key_d   = aes_key;
          text_d  = aes_plaintext;
          rnd_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tmr_d   = TMR_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        // dp_done is checked first so a reply on the last allowed cycle still counts
        if (dp_done) begin
          if (rnd_q == LAST_RND) begin
            ct_d    = dp_state;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            rnd_d   = rnd_q + 4'd1;
            state_d = ISSUE;
          end
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dp_start       = (state_q == ISSUE);
  assign dp_round       = rnd_q;
  assign dp_final       = (rnd_q == LAST_RND);
  assign dp_key         = key_q;
  assign dp_text        = text_q;
  assign aes_ciphertext = ct_q;
  assign DONE           = done_q;
  assign busy           = busy_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: a behavioural AES-128 datapath answers the round
// commands; results are compared against a full-cipher reference and latency rules.
module tb_aes_round_sequencer;
  localparam int NR = 10;
  localparam int TO = 64;

  logic         HCLK;
  logic         HRESETn;
  logic         start;
  logic [127:0] aes_key;
  logic [127:0] aes_plaintext;
  logic         dp_start;
  logic [3:0]   dp_round;
  logic         dp_final;
  logic [127:0] dp_key;
  logic [127:0] dp_text;
  logic         dp_done;
  logic [127:0] dp_state;
  logic [127:0] aes_ciphertext;
  logic         DONE;
  logic         busy;
  logic         err_timeout;

  aes_round_sequencer #(.NUM_ROUNDS(NR), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .aes_key(aes_key), .aes_plaintext(aes_plaintext),
    .dp_start(dp_start), .dp_round(dp_round), .dp_final(dp_final),
    .dp_key(dp_key), .dp_text(dp_text),
    .dp_done(dp_done), .dp_state(dp_state),
    .aes_ciphertext(aes_ciphertext), .DONE(DONE), .busy(busy), .err_timeout(err_timeout)
  );

  int          cyc;
  int          n_chk;
  int          n_fail;
  logic [7:0]  sbox_t [256];
  int          lat_tab [NR+1];
  int          inject_cnt;
  logic [4:0]  start_log [$];

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- AES reference helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xt(rc);
    return rc;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = rk[127:96]; w1 = rk[95:64]; w2 = rk[63:32]; w3 = rk[31:0];
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input bit fin);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   x0, x1, x2, x3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[c*4+r] = a[((c+r)%4)*4+r];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[c*4]; x1 = b[c*4+1]; x2 = b[c*4+2]; x3 = b[c*4+3];
        b[c*4]   = gm(x0, 8'h02) ^ gm(x1, 8'h03) ^ x2 ^ x3;
        b[c*4+1] = x0 ^ gm(x1, 8'h02) ^ gm(x2, 8'h03) ^ x3;
        b[c*4+2] = x0 ^ x1 ^ gm(x2, 8'h02) ^ gm(x3, 8'h03);
        b[c*4+3] = gm(x0, 8'h03) ^ x1 ^ x2 ^ gm(x3, 8'h02);
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ rk;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] s, rk;
    s = p ^ k; rk = k;
    for (int r = 1; r <= NR; r++) begin
      rk = key_next(rk, rcon_of(r));
      s  = aes_round(s, rk, r == NR);
    end
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- datapath model + command log ----------------
  initial begin
    logic [127:0] m_s, m_rk;
    bit           pending;
    int           cnt;
    int           inject_seen;
    dp_done = 1'b0; dp_state = '0;
    pending = 0; cnt = 0; inject_seen = 0; m_s = '0; m_rk = '0;
    forever begin
      @(negedge HCLK);
      dp_done  = 1'b0;
      dp_state = rnd128();
      if (!HRESETn) begin
        pending = 0;
      end else begin
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            dp_done  = 1'b1;
            dp_state = m_s;
            pending  = 0;
          end
        end
        if (dp_start) begin
          start_log.push_back({dp_final, dp_round});
          if (dp_round == 4'd0) begin
            m_s = dp_text ^ dp_key; m_rk = dp_key;
          end else begin
            m_rk = key_next(m_rk, rcon_of(int'(dp_round)));
            m_s  = aes_round(m_s, m_rk, dp_final);
          end
          if (dp_round <= 4'(NR) && lat_tab[dp_round] > 0) begin
            pending = 1; cnt = lat_tab[dp_round];
          end
        end
      end
      if (inject_cnt != inject_seen) begin
        inject_seen = inject_cnt;
        dp_done     = 1'b1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_seq(input string nm, input int idx0, input int n);
    bit         ok;
    logic [4:0] e;
    ok = (start_log.size() - idx0 == n);
    if (ok)
      for (int i = 0; i < n; i++) begin
        e = {(i == NR), 4'(i)};
        if (start_log[idx0+i] !== e) ok = 0;
      end
    chk({nm, "_count"}, 128'(start_log.size() - idx0), 128'(n));
    chk({nm, "_rounds"}, 128'(ok), 128'(1));
  endtask

  task automatic do_run(input logic [127:0] k, input logic [127:0] p, input bit scramble,
                        output int lat_cyc, output int idx0);
    int t0;
    @(negedge HCLK);
    aes_key = k; aes_plaintext = p; start = 1'b1;
    idx0 = start_log.size(); t0 = cyc;
    @(negedge HCLK);
    start = 1'b0;
    chk("done_clear_on_trig", 128'(DONE), 128'(0));
    chk("busy_after_trig", 128'(busy), 128'(1));
    if (scramble) begin
      aes_key = rnd128(); aes_plaintext = rnd128();
    end
    while (!DONE && (cyc - t0) < 3000) @(negedge HCLK);
    if (!DONE) chk("run_bound_expired", 128'(DONE), 128'(1));
    lat_cyc = cyc - t0;
    chk("dp_key_stable", dp_key, k);
    chk("dp_text_stable", dp_text, p);
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    int           lat;
    int           slow_rnd;
    int           slow_lat;
    logic [127:0] ct;
    int           cycles;
    bit           err;
  } vec_t;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  // ---------------- main test ----------------
  initial begin
    vec_t         tab [7];
    int           lc, idx0, idx1, exp_cyc, n_exp;
    logic [127:0] k, p, v;

    n_chk = 0; n_fail = 0; inject_cnt = 0;
    HRESETn = 1'b0; start = 1'b0; aes_key = '0; aes_plaintext = '0;
    for (int r = 0; r <= NR; r++) lat_tab[r] = 1;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[x] = s;
    end

    tab[0] = '{K_C1, P_C1, 1, 0, 1,  CT_C1, 23, 0};
    tab[1] = '{K_C1, P_C1, 3, 0, 3,  CT_C1, 45, 0};
    tab[2] = '{K_B,  P_B,  1, 7, 64, CT_B,  86, 0};
    tab[3] = '{K_C1, P_C1, 1, 4, 0,  CT_B,  74, 1};
    tab[4] = '{K_C1, P_C1, 1, 2, 65, CT_B,  70, 1};
    tab[5] = '{K_B,  P_B,  2, 0, 2,  CT_B,  34, 0};
    tab[6] = '{K_C1, P_C1, 1, 10, 64, CT_C1, 86, 0};

    @(negedge HCLK); #1;
    chk("reset_ctrl", 128'({dp_start, dp_round, dp_final, DONE, busy, err_timeout}), 128'(0));
    chk("reset_ct", aes_ciphertext, 128'(0));
    chk("reset_key", dp_key, 128'(0));
    chk("ref_model_fips", aes_encrypt(K_C1, P_C1), CT_C1);
    @(negedge HCLK); HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // table-driven runs
    for (int t = 0; t < 7; t++) begin
      for (int r = 0; r <= NR; r++) lat_tab[r] = (r == tab[t].slow_rnd) ? tab[t].slow_lat : tab[t].lat;
      do_run(tab[t].key, tab[t].pt, 0, lc, idx0);
      chk($sformatf("tab%0d_cycles", t), 128'(lc), 128'(tab[t].cycles));
      chk($sformatf("tab%0d_ct", t), aes_ciphertext, tab[t].ct);
      chk($sformatf("tab%0d_flags", t), 128'({DONE, busy, err_timeout}), 128'({1'b1, 1'b0, tab[t].err}));
      if (tab[t].err) begin
        chk($sformatf("tab%0d_starts", t), 128'(start_log.size() - idx0), 128'(tab[t].slow_rnd + 1));
      end else begin
        chk_seq($sformatf("tab%0d_seq", t), idx0, NR + 1);
      end
      repeat (3) @(negedge HCLK);
    end

    // randomized runs with per-round latency and inputs changing mid-run
    for (int it = 0; it < 8; it++) begin
      k = rnd128(); p = rnd128();
      exp_cyc = 2*NR + 3;
      for (int r = 0; r <= NR; r++) begin
        lat_tab[r] = $urandom_range(1, 4);
        exp_cyc += lat_tab[r] - 1;
      end
      do_run(k, p, 1, lc, idx0);
      chk($sformatf("rand%0d_cycles", it), 128'(lc), 128'(exp_cyc));
      chk($sformatf("rand%0d_ct", it), aes_ciphertext, aes_encrypt(k, p));
      chk($sformatf("rand%0d_err", it), 128'(err_timeout), 128'(0));
      chk_seq($sformatf("rand%0d_seq", it), idx0, NR + 1);
      repeat (2) @(negedge HCLK);
    end

    // start held high: one run; release and re-raise: a second run
    for (int r = 0; r <= NR; r++) lat_tab[r] = 1;
    @(negedge HCLK);
    aes_key = K_B; aes_plaintext = P_B; start = 1'b1; idx0 = start_log.size();
    repeat (100) @(negedge HCLK);
    chk("held_one_run", 128'(start_log.size() - idx0), 128'(NR + 1));
    start = 1'b0;
    @(negedge HCLK); start = 1'b1;
    repeat (40) @(negedge HCLK);
    chk("held_two_runs", 128'(start_log.size() - idx0), 128'(2*(NR + 1)));
    chk("held_ct", aes_ciphertext, CT_B);
    // second edge while busy is dropped
    start = 1'b0;
    @(negedge HCLK); start = 1'b1; idx1 = start_log.size();
    @(negedge HCLK); start = 1'b0;
    repeat (5) @(negedge HCLK); start = 1'b1;
    @(negedge HCLK); start = 1'b0;
    repeat (60) @(negedge HCLK);
    chk("busy_edge_ignored", 128'(start_log.size() - idx1), 128'(NR + 1));
    chk("busy_edge_flags", 128'({DONE, busy, err_timeout}), 128'(3'b100));

    // reset asserted during round 6
    @(negedge HCLK);
    aes_key = K_C1; aes_plaintext = P_C1; start = 1'b1;
    @(negedge HCLK); start = 1'b0;
    lc = 0;
    while (!(dp_start && dp_round == 4'd6) && lc < 100) begin
      @(negedge HCLK); lc++;
    end
    chk("reach_round6", 128'(dp_start && dp_round == 4'd6), 128'(1));
    HRESETn = 1'b0; #1;
    chk("midrst_ctrl", 128'({dp_start, dp_round, dp_final, DONE, busy, err_timeout}), 128'(0));
    chk("midrst_key_text", dp_key | dp_text, 128'(0));
    chk("midrst_ct", aes_ciphertext, 128'(0));
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    n_exp = start_log.size();
    inject_cnt = inject_cnt + 1;
    repeat (5) @(negedge HCLK);
    v = 128'({DONE, busy, err_timeout});
    chk("late_done_flags", v, 128'(0));
    chk("late_done_ct", aes_ciphertext, 128'(0));
    chk("late_done_no_cmd", 128'(start_log.size() - n_exp), 128'(0));
    do_run(K_C1, P_C1, 1, lc, idx0);
    chk("after_rst_cycles", 128'(lc), 128'(23));
    chk("after_rst_ct", aes_ciphertext, CT_C1);
    chk_seq("after_rst_seq", idx0, NR + 1);

    repeat (3) @(negedge HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
